// File: rtl/spi_rtc_ctrl.sv
// spi_rtc_ctrl: cartridge-bus mapped SPI master for an RTC chip.
// Registers at cart_a[7:3] = 5'b10111: 0 DATA, 1 CTRL/STATUS, 2 DIV, 3-7 read 8'hFF.
// SPI mode 0, MSB first; each sck half-period lasts DIV+1 phi2 cycles.
// Optional feature macro: SPI_RTC_AUTO_RD_EN -- an idle DATA read starts a
// transfer of 8'hFF so the next RX byte can be fetched with reads alone.
module spi_rtc_ctrl #(
    parameter int unsigned DIV_W = 8
) (
    input  logic       phi2,
    input  logic       reset_n,
    input  logic       cctl_n,
    input  logic       r_w,
    input  logic [7:0] cart_a,
    input  logic [7:0] cart_d_in,
    output logic [7:0] cart_d_out,
    output logic       cart_d_oe,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       sel_n,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    state_t           state;
    logic [7:0]       shift;
    logic [7:0]       rx;
    logic [2:0]       bit_cnt;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_work;
    logic [DIV_W-1:0] cnt;
    logic             cs_en;
    logic             ovr;

    logic             hit;
    logic [2:0]       off;
    logic             wr_data;
    logic             wr_ctrl;
    logic             wr_div;
    logic             start;
    logic [7:0]       start_byte;
    logic [DIV_W-1:0] div_wr;
    logic [7:0]       div_rd;

    assign hit     = ~cctl_n & (cart_a[7:3] == 5'b10111);
    assign off     = cart_a[2:0];
    assign wr_data = hit & ~r_w & (off == 3'd0);
    assign wr_ctrl = hit & ~r_w & (off == 3'd1);
    assign wr_div  = hit & ~r_w & (off == 3'd2);

`ifdef SPI_RTC_AUTO_RD_EN
    logic rd_data;
    assign rd_data    = hit & r_w & (off == 3'd0);
    assign start      = wr_data | rd_data;
    assign start_byte = wr_data ? cart_d_in : 8'hFF;
`else
    assign start      = wr_data;
    assign start_byte = cart_d_in;
`endif

    // Bus-width adaptation of the divider register for any DIV_W.
    generate
        if (DIV_W > 8) begin : g_div_wide
            assign div_wr = {{(DIV_W-8){1'b0}}, cart_d_in};
            assign div_rd = div_reg[7:0];
        end else if (DIV_W == 8) begin : g_div_byte
            assign div_wr = cart_d_in;
            assign div_rd = div_reg;
        end else begin : g_div_narrow
            assign div_wr = cart_d_in[DIV_W-1:0];
            assign div_rd = {{(8-DIV_W){1'b0}}, div_reg};
        end
    endgenerate

    assign cart_d_oe = hit & r_w;
    assign sel_n     = ~cs_en;

    // Read-data mux from the current register values.
    always_comb begin
        cart_d_out = 8'hFF;
        case (off)
            3'd0:    cart_d_out = rx;
            3'd1:    cart_d_out = {busy, ovr, 5'b0, cs_en};
            3'd2:    cart_d_out = div_rd;
            default: cart_d_out = 8'hFF;
        endcase
    end

    // Register writes, overrun tracking and the SPI shift FSM.
    // miso is shifted into the LSB on the rising sck edge and the next TX bit
    // (now at shift[7]) is driven on the falling edge; this keeps one shift
    // register for both directions without losing untransmitted TX bits.
    always_ff @(posedge phi2 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            cs_en    <= 1'b0;
            ovr      <= 1'b0;
            div_reg  <= '0;
            div_work <= '0;
            cnt      <= '0;
            rx       <= 8'hFF;
            shift    <= '0;
            bit_cnt  <= '0;
        end else begin
            if (wr_ctrl) begin
                if (cart_d_in[7]) begin
                    ovr <= 1'b0;
                end else if (busy) begin
                    ovr <= 1'b1;
                end
                if (!busy) begin
                    cs_en <= cart_d_in[0];
                end
            end else if (wr_data && busy) begin
                ovr <= 1'b1;
            end

            if (wr_div) begin
                div_reg <= div_wr;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        shift    <= start_byte;
                        div_work <= div_reg;
                        busy     <= 1'b1;
                        mosi     <= start_byte[7];
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (cnt == div_work) begin
                        cnt   <= '0;
                        sck   <= 1'b1;
                        shift <= {shift[6:0], miso};
                        state <= HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == div_work) begin
                        cnt     <= '0;
                        sck     <= 1'b0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            busy  <= 1'b0;
                            rx    <= shift;
                            state <= IDLE;
                        end else begin
                            mosi  <= shift[7];
                            state <= LOW;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rtc_ctrl.sv
// Self-checking bench for spi_rtc_ctrl (DIV_W = 8).
// A transfer-level model predicts sck/mosi/busy/sel_n/read data every cycle;
// directed sections pin the model with hand-computed values.
// Honors SPI_RTC_AUTO_RD_EN the same way the design does.
module tb_spi_rtc_ctrl;

    logic       phi2 = 1'b0;
    logic       reset_n = 1'b0;
    logic       cctl_n = 1'b1;
    logic       r_w = 1'b1;
    logic [7:0] cart_a = '0;
    logic [7:0] cart_d_in = '0;
    logic       miso = 1'b0;
    logic [7:0] cart_d_out;
    logic       cart_d_oe;
    logic       sck;
    logic       mosi;
    logic       sel_n;
    logic       busy;

    spi_rtc_ctrl #(.DIV_W(8)) dut (
        .phi2       (phi2),
        .reset_n    (reset_n),
        .cctl_n     (cctl_n),
        .r_w        (r_w),
        .cart_a     (cart_a),
        .cart_d_in  (cart_d_in),
        .cart_d_out (cart_d_out),
        .cart_d_oe  (cart_d_oe),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .sel_n      (sel_n),
        .busy       (busy)
    );

    always #5 phi2 = ~phi2;

    int n_checks = 0;
    int n_fail   = 0;
    bit miso_rand = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %02h required %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transfer-level reference model ----------------
    bit         m_busy = 1'b0;
    int         m_k = 0;          // edges since the start edge
    int         m_d = 0;          // divider latched for this transfer
    logic [7:0] m_tx = '0;
    logic [7:0] m_acc = '0;
    logic [7:0] m_rx = 8'hFF;
    logic [7:0] m_div = '0;
    bit         m_cs = 1'b0;
    bit         m_ovr = 1'b0;
    bit         m_mlast = 1'b0;
    bit         m_pre;
    bit         m_hit;
    logic [2:0] m_off;

    task m_start(input logic [7:0] b);
        m_busy = 1'b1;
        m_k    = 0;
        m_d    = int'(m_div);
        m_tx   = b;
        m_acc  = '0;
    endtask

    always @(posedge phi2 or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0; m_k = 0; m_d = 0; m_rx = 8'hFF; m_div = '0;
            m_cs = 1'b0; m_ovr = 1'b0; m_mlast = 1'b0;
        end else begin
            m_pre = m_busy;
            m_hit = !cctl_n && (cart_a[7:3] == 5'b10111);
            m_off = cart_a[2:0];
            if (m_busy) begin
                m_k++;
                // rising sck for bit i occurs at k = (2i+1)(d+1)
                if (m_k % (2 * (m_d + 1)) == m_d + 1)
                    m_acc[7 - m_k / (2 * (m_d + 1))] = miso;
                if (m_k == 16 * (m_d + 1)) begin
                    m_busy  = 1'b0;
                    m_rx    = m_acc;
                    m_mlast = m_tx[0];
                end
            end
            if (m_hit && !r_w) begin
                case (m_off)
                    3'd0: begin
                        if (m_pre) m_ovr = 1'b1;
                        else m_start(cart_d_in);
                    end
                    3'd1: begin
                        if (cart_d_in[7]) m_ovr = 1'b0;
                        else if (m_pre) m_ovr = 1'b1;
                        if (!m_pre) m_cs = cart_d_in[0];
                    end
                    3'd2: m_div = cart_d_in;
                    default: ;
                endcase
            end
`ifdef SPI_RTC_AUTO_RD_EN
            if (m_hit && r_w && m_off == 3'd0 && !m_pre) m_start(8'hFF);
`endif
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge phi2) begin
        int         p;
        logic       e_sck;
        logic       e_mosi;
        logic       e_oe;
        logic [7:0] e_dout;
        if (reset_n) begin
            p      = m_k / (m_d + 1);
            e_sck  = m_busy && (p % 2 == 1);
            e_mosi = m_mlast;
            if (m_busy) e_mosi = m_tx[7 - p / 2];
            chk("sck", sck, e_sck);
            chk("mosi", mosi, e_mosi);
            chk("busy", busy, m_busy);
            chk("sel_n", sel_n, !m_cs);
            e_oe = !cctl_n && (cart_a[7:3] == 5'b10111) && r_w;
            chk("oe", cart_d_oe, e_oe);
            if (e_oe) begin
                case (cart_a[2:0])
                    3'd0:    e_dout = m_rx;
                    3'd1:    e_dout = {m_busy, m_ovr, 5'b0, m_cs};
                    3'd2:    e_dout = m_div;
                    default: e_dout = 8'hFF;
                endcase
                chk("dout", cart_d_out, e_dout);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task tick();
        @(posedge phi2);
        #1;
        if (miso_rand) miso = 1'($urandom_range(0, 1));
    endtask

    task bus_raw(input logic cc, input logic rw, input logic [7:0] a, input logic [7:0] d);
        cctl_n = cc; r_w = rw; cart_a = a; cart_d_in = d;
        tick();
        cctl_n = 1'b1;
    endtask

    task bus_write(input logic [2:0] o, input logic [7:0] d);
        bus_raw(1'b0, 1'b0, {5'b10111, o}, d);
    endtask

    task bus_read(input logic [2:0] o, output logic [7:0] v);
        cctl_n = 1'b0; r_w = 1'b1; cart_a = {5'b10111, o};
        @(negedge phi2);
        v = cart_d_out;
        tick();
        cctl_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] pat;
        logic [7:0] bits;
        logic [7:0] a;
        int         rises;
        int         hi;
        logic       prev;

        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // after reset
        @(negedge phi2);
        chk("rst_sck", sck, 1'b0);
        chk("rst_sel_n", sel_n, 1'b1);
        chk("rst_mosi", mosi, 1'b0);
        tick();
        bus_read(3'd1, v); chk("rst_status", v, 8'h00);
        bus_read(3'd0, v); chk("rst_data", v, 8'hFF);
        bus_read(3'd2, v); chk("rst_div", v, 8'h00);
        bus_read(3'd5, v); chk("unmapped_rd", v, 8'hFF);
        repeat (20) tick();

        // DIV=3, A5 out, 3C in
        bus_write(3'd2, 8'd3);
        bus_write(3'd1, 8'h01);
        bus_write(3'd0, 8'hA5);
        pat = 8'h3C; bits = '0; rises = 0; hi = 0; prev = 1'b0;
        for (int c = 0; c < 64; c++) begin
            miso = pat[7 - c / 8];
            @(negedge phi2);
            if (sck && !prev) begin
                bits = {bits[6:0], mosi};
                rises++;
            end
            if (sck) hi++;
            prev = sck;
            if (c == 63) chk("busy_before_64", busy, 1'b1);
            tick();
        end
        @(negedge phi2);
        chk("busy_after_64", busy, 1'b0);
        chk("mosi_bits", bits, 8'hA5);
        chk("sck_pulses", 8'(rises), 8'd8);
        chk("sck_high_cycles", 8'(hi), 8'd32);
        tick();
        bus_read(3'd1, v); chk("status_after_xfer", v, 8'h01);
        bus_read(3'd0, v); chk("rx_3c", v, 8'h3C);
        repeat (20) tick();

        // DIV=0, overrun by second DATA write
        miso = 1'b0;
        bus_write(3'd2, 8'd0);
        bus_write(3'd0, 8'h5A);
        repeat (4) tick();
        bus_write(3'd0, 8'hC3);
        repeat (10) tick();
        @(negedge phi2);
        chk("busy_at_15", busy, 1'b1);
        tick();
        @(negedge phi2);
        chk("busy_at_16", busy, 1'b0);
        tick();
        bus_read(3'd1, v); chk("status_ovr", v, 8'h41);
        bus_write(3'd1, 8'h81);
        bus_read(3'd1, v); chk("status_ovr_clr", v, 8'h01);
        bus_read(3'd0, v); chk("rx_zero", v, 8'h00);
        repeat (20) tick();

        // reset mid-transfer at bit 4
        miso_rand = 1'b1;
        bus_write(3'd2, 8'd3);
        bus_write(3'd0, 8'h96);
        repeat (34) tick();
        @(negedge phi2);
        chk("mid_busy", busy, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_sck", sck, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_sel_n", sel_n, 1'b1);
        #1 reset_n = 1'b1;
        tick();
        bus_read(3'd1, v); chk("abort_status", v, 8'h00);
        bus_read(3'd0, v); chk("abort_rx", v, 8'hFF);
        bus_read(3'd2, v); chk("abort_div", v, 8'h00);
        repeat (20) tick();

        // idle DATA read
        bus_read(3'd0, v);
        for (int c = 0; c < 16; c++) begin
            @(negedge phi2);
`ifdef SPI_RTC_AUTO_RD_EN
            if (c == 0) chk("auto_busy", busy, 1'b1);
            chk("auto_mosi", mosi, 1'b1);
`else
            chk("noauto_busy", busy, 1'b0);
`endif
            tick();
        end

        // maximum divider
        bus_write(3'd2, 8'hFF);
        bus_write(3'd0, 8'h69);
        repeat (4095) tick();
        @(negedge phi2);
        chk("div255_busy_4095", busy, 1'b1);
        tick();
        @(negedge phi2);
        chk("div255_busy_4096", busy, 1'b0);
        tick();
        bus_write(3'd2, 8'd0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 9))
                0, 1: bus_write(3'd0, 8'($urandom));
                2:    bus_write(3'd1, 8'($urandom));
                3: begin
                    v = 8'($urandom_range(0, 4));
                    if (v == 8'd4) v = 8'd7;
                    bus_write(3'd2, v);
                end
                4:    bus_write(3'($urandom_range(3, 7)), 8'($urandom));
                5, 6: bus_raw(1'b0, 1'b1, {5'b10111, 3'($urandom_range(0, 7))}, 8'($urandom));
                7: begin
                    a = 8'($urandom);
                    if ($urandom_range(0, 1) == 0) begin
                        bus_raw(1'b1, 1'($urandom_range(0, 1)), {5'b10111, a[2:0]}, 8'($urandom));
                    end else begin
                        if (a[7:3] == 5'b10111) a[7] = 1'b0;
                        bus_raw(1'b0, 1'($urandom_range(0, 1)), a, 8'($urandom));
                    end
                end
                default: repeat ($urandom_range(1, 20)) tick();
            endcase
        end
        repeat (200) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_rtc_ctrl.md
SPI_RTC_CTRL -- requirements
Module: spi_rtc_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8, giving the width of the SCK half-period divider register.
REQ-002 SHALL have port phi2, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port cctl_n, input, 1 bit: cartridge control-area strobe, active-low.
REQ-005 SHALL have port r_w, input, 1 bit: bus direction; 1 = read, 0 = write.
REQ-006 SHALL have port cart_a, input, 8 bits: cartridge address bits [7:0].
REQ-007 SHALL have port cart_d_in, input, 8 bits: bus write data.
REQ-008 SHALL have port cart_d_out, output, 8 bits: bus read data.
REQ-009 SHALL have port cart_d_oe, output, 1 bit: read-data drive enable.
REQ-010 SHALL have port sck, output, 1 bit: SPI clock.
REQ-011 SHALL have port mosi, output, 1 bit: SPI data out.
REQ-012 SHALL have port miso, input, 1 bit: SPI data in.
REQ-013 SHALL have port sel_n, output, 1 bit: RTC chip select, active-low.
REQ-014 SHALL have port busy, output, 1 bit: a transfer is in progress.

Function
REQ-015 SHALL decode a hit as: cctl_n=0 and cart_a[7:3]=5'b10111; the register offset is cart_a[2:0].
REQ-016 SHALL use this register map: offset 0 DATA (write = TX byte, read = RX byte); offset 1 CTRL/STATUS; offset 2 DIV; offsets 3-7 read 8'hFF and ignore writes.
REQ-017 SHALL set cart_d_oe = hit & r_w combinationally; cart_d_out SHALL be combinational from the register values present before the next edge.
REQ-018 SHALL return on a STATUS read {busy, ovr, 5'b0, cs_en}.
REQ-019 SHALL, on a CTRL write, load cs_en from bit0 and clear ovr when bit7=1.
REQ-020 SHALL drive sel_n = ~cs_en.
REQ-021 SHALL, on a DATA write while idle, load the shift register, latch DIV into the working divider, set busy at that edge, and drive mosi = TX bit7 from that edge.
REQ-022 SHALL use SPI mode 0, MSB first, with sck low when idle.
REQ-023 SHALL use FSM states IDLE -> LOW -> HIGH -> ... -> IDLE; each LOW and HIGH phase lasts exactly DIV+1 phi2 cycles.
REQ-024 SHALL, on LOW->HIGH, raise sck and sample miso into the shift register LSB.
REQ-025 SHALL, on HIGH->LOW, lower sck, shift, and present the next TX bit on mosi.
REQ-026 SHALL count 8 bits with a 3-bit counter.
REQ-027 SHALL, after the 8th HIGH phase, enter IDLE with sck=0, clear busy, and load the RX byte, exactly 16*(DIV+1) cycles after the start edge.
REQ-028 SHALL treat DIV=0 as a 1-cycle half-period; DIV=2^DIV_W-1 SHALL be legal.
REQ-029 SHALL, when DATA or CTRL is written while busy, ignore the write data, leave the transfer unaffected, and set ovr; a CTRL write with bit7=1 while busy SHALL still clear ovr, and the clear SHALL take priority over setting.
REQ-030 SHALL apply a DIV write while busy to the next transfer only.
REQ-031 SHALL, for a DATA read in the same cycle as completion, return the previous RX byte.
REQ-032 SHALL keep mosi holding the last transmitted bit while idle.

Reset
REQ-033 SHALL, on reset_n=0, immediately set: state IDLE, busy=0, sck=0, mosi=0, sel_n=1, cs_en=0, ovr=0, DIV=0, RX=8'hFF, bit counter=0.
REQ-034 SHALL abort a transfer at reset assertion without completing it; the RX byte SHALL read 8'hFF after release.

Configuration
REQ-035 SHALL, with macro SPI_RTC_AUTO_RD_EN defined, start a transfer of TX=8'hFF at the rising edge ending a DATA read that occurs while idle; a read while busy SHALL NOT start a transfer or set ovr.
REQ-036 SHALL, without SPI_RTC_AUTO_RD_EN, have DATA reads no side effects.

Verification
REQ-037 SHALL cover: after reset -> STATUS=8'h00, DATA=8'hFF, sck=0, sel_n=1.
REQ-038 SHALL cover: DIV=3, CTRL=8'h01, DATA=8'hA5, miso pattern 8'h3C -> mosi bits 10100101, 8 sck pulses 4 high/4 low, busy cleared after 64 cycles, DATA read 8'h3C.
REQ-039 SHALL cover: DIV=0, DATA write then a second DATA write 5 cycles later -> first transfer completes in 16 cycles unchanged, STATUS=8'h41; CTRL=8'h81 -> STATUS=8'h01.
REQ-040 SHALL cover: reset_n pulsed low mid-transfer at bit 4 -> sck=0 and busy=0 immediately, DATA=8'hFF.
REQ-041 SHALL cover: SPI_RTC_AUTO_RD_EN defined, idle DATA read -> busy=1 next cycle, mosi constant 1 for 8 bits; same read with macro undefined -> busy stays 0.
